// File: rtl/spike_tx_arbiter.sv
// spike_tx_arbiter: shares one spike output channel among N_REQ requesters.
// A grant starts a pulse of the latched width, then a refractory gap of the
// latched length. Every output is a register.
// Optional feature macro: SPIKE_ARB_RR_EN selects round-robin arbitration;
// when it is undefined, arbitration is fixed priority (lowest index wins).
module spike_tx_arbiter #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 8,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [N_REQ-1:0] req,
   input  logic [CNT_W-1:0] pulse_width,
   input  logic [CNT_W-1:0] pulse_gap,
   output logic [N_REQ-1:0] grant,
   output logic             pulse_out,
   output logic [ID_W-1:0]  pulse_id,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] gap_reg;
   logic [N_REQ-1:0] grant_reg;
   logic             pulse_out_reg;
   logic [ID_W-1:0]  pulse_id_reg;
   logic             busy_reg;

   logic             win_valid;
   logic [ID_W-1:0]  win_id;
   logic [N_REQ-1:0] win_onehot;
   logic             do_grant;

   // A new winner is only taken from IDLE while enabled.
   assign do_grant = (state_reg == IDLE) && enable && win_valid;

   // One-hot decode of the winning index for the grant strobe.
   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
         assign win_onehot[gi] = (win_id == ID_W'(gi));
      end
   endgenerate

`ifdef SPIKE_ARB_RR_EN
   logic [ID_W-1:0] ptr_reg;
   logic [ID_W:0]   rr_idx;

   // Round-robin search: walk from the pointer upward (wrapping); the loop runs
   // from the farthest offset down so the nearest set request is assigned last.
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      rr_idx    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         rr_idx = {1'b0, ptr_reg} + (ID_W + 1)'(i);
         if (rr_idx >= (ID_W + 1)'(N_REQ)) begin
            rr_idx = rr_idx - (ID_W + 1)'(N_REQ);
         end
         if (req[rr_idx[ID_W-1:0]]) begin
            win_valid = 1'b1;
            win_id    = rr_idx[ID_W-1:0];
         end
      end
   end

   // Pointer moves to one past the winner after every grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (do_grant) begin
         if (win_id == ID_W'(N_REQ - 1)) begin
            ptr_reg <= '0;
         end else begin
            ptr_reg <= win_id + 1'b1;
         end
      end
   end
`else
   // Fixed priority: the lowest-index set request wins.
   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_valid = 1'b1;
            win_id    = ID_W'(i);
         end
      end
   end
`endif

   // Main FSM: counters hold remaining cycles minus one, so the count of 0 marks
   // the last cycle of a phase. Width and gap are latched at grant time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         gap_reg       <= '0;
         grant_reg     <= '0;
         pulse_out_reg <= 1'b0;
         pulse_id_reg  <= '0;
         busy_reg      <= 1'b0;
      end else begin
         grant_reg <= '0;
         case (state_reg)
            IDLE: begin
               if (do_grant) begin
                  state_reg     <= PULSE;
                  grant_reg     <= win_onehot;
                  pulse_out_reg <= 1'b1;
                  pulse_id_reg  <= win_id;
                  busy_reg      <= 1'b1;
                  gap_reg       <= pulse_gap;
                  // A zero width still produces a single-cycle pulse.
                  if (pulse_width == '0) begin
                     cnt_reg <= '0;
                  end else begin
                     cnt_reg <= pulse_width - 1'b1;
                  end
               end
            end
            PULSE: begin
               if (cnt_reg == '0) begin
                  pulse_out_reg <= 1'b0;
                  if (gap_reg != '0) begin
                     state_reg <= GAP;
                     cnt_reg   <= gap_reg - 1'b1;
                  end else begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            GAP: begin
               if (cnt_reg == '0) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               pulse_out_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign grant     = grant_reg;
   assign pulse_out = pulse_out_reg;
   assign pulse_id  = pulse_id_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_spike_tx_arbiter.sv
// Testbench for spike_tx_arbiter (N_REQ=4, CNT_W=8, ID_W=2).
// Expected per-cycle outputs are pushed to a scoreboard queue when stimulus is
// applied and popped on each falling edge. Honours SPIKE_ARB_RR_EN for the
// expected winners.
module tb_spike_tx_arbiter;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [3:0] req;
   logic [7:0] pulse_width;
   logic [7:0] pulse_gap;
   logic [3:0] grant;
   logic       pulse_out;
   logic [1:0] pulse_id;
   logic       busy;

   int checks   = 0;
   int failures = 0;

   spike_tx_arbiter #(.N_REQ(4), .CNT_W(8), .ID_W(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .req         (req),
      .pulse_width (pulse_width),
      .pulse_gap   (pulse_gap),
      .grant       (grant),
      .pulse_out   (pulse_out),
      .pulse_id    (pulse_id),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] grant;
      logic       pulse;
      logic [1:0] id;
      logic       busy;
   } exp_t;

   exp_t sb_q[$];

   typedef struct {
      logic [3:0] req;
      logic [7:0] w;
      logic [7:0] g;
      logic [1:0] id_fp;   // expected winner, fixed priority
      logic [1:0] id_rr;   // expected winner, round-robin (pointer carried over)
   } vec_t;

   vec_t vecs[7];

   task automatic push_exp(input logic [3:0] g, input logic p, input logic [1:0] id, input logic b);
      exp_t e;
      e.grant = g;
      e.pulse = p;
      e.id    = id;
      e.busy  = b;
      sb_q.push_back(e);
   endtask

   // Expected trace of one spike: grant cycle, remaining high cycles, gap, idle tail.
   task automatic push_train(input logic [1:0] id, input int w, input int g, input int n_idle);
      int weff;
      logic [3:0] oh;
      weff = (w == 0) ? 1 : w;
      oh = 4'b0001 << id;
      push_exp(oh, 1'b1, id, 1'b1);
      for (int k = 1; k < weff; k++) push_exp(4'b0000, 1'b1, id, 1'b1);
      for (int k = 0; k < g; k++) push_exp(4'b0000, 1'b0, id, 1'b1);
      for (int k = 0; k < n_idle; k++) push_exp(4'b0000, 1'b0, id, 1'b0);
   endtask

   task automatic tick_check(input string name);
      exp_t e;
      @(negedge clk);
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty at t=%0t", name, $time);
      end else begin
         e = sb_q.pop_front();
         if (grant !== e.grant || pulse_out !== e.pulse || pulse_id !== e.id || busy !== e.busy) begin
            failures++;
            $display("FAIL %s t=%0t: got grant=%b pulse=%b id=%0d busy=%b, want grant=%b pulse=%b id=%0d busy=%b",
                     name, $time, grant, pulse_out, pulse_id, busy, e.grant, e.pulse, e.id, e.busy);
         end
      end
   endtask

   // Safety net: the stimulus uses only bounded waits, this catches anything else.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [1:0] rr_ids[5];
      logic [1:0] id;

      // {req, W, G, fixed-priority winner, round-robin winner}
      vecs[0] = '{4'b0001, 8'd4,   8'd2,   2'd0, 2'd0};
      vecs[1] = '{4'b0100, 8'd0,   8'd0,   2'd2, 2'd2};
      vecs[2] = '{4'b1010, 8'd2,   8'd1,   2'd1, 2'd3};
      vecs[3] = '{4'b0110, 8'd3,   8'd0,   2'd1, 2'd1};
      vecs[4] = '{4'b1000, 8'd1,   8'd3,   2'd3, 2'd3};
      vecs[5] = '{4'b1111, 8'd255, 8'd255, 2'd0, 2'd0};
      vecs[6] = '{4'b0011, 8'd1,   8'd0,   2'd0, 2'd1};

      // Reset, then reset held while a request is present: reset wins.
      rst = 1'b1; enable = 1'b0; req = 4'b0000; pulse_width = 8'd0; pulse_gap = 8'd0;
      push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
      tick_check("reset");
      req = 4'b1111; enable = 1'b1;
      push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
      tick_check("reset_vs_req");
      rst = 1'b0; req = 4'b0000;

      // Table: one spike per vector; width/gap inputs are scrambled after grant.
      for (int v = 0; v < 7; v++) begin
`ifdef SPIKE_ARB_RR_EN
         id = vecs[v].id_rr;
`else
         id = vecs[v].id_fp;
`endif
         req = vecs[v].req; pulse_width = vecs[v].w; pulse_gap = vecs[v].g; enable = 1'b1;
         push_train(id, int'(vecs[v].w), int'(vecs[v].g), 1);
         n = sb_q.size();
         for (int k = 0; k < n; k++) begin
            tick_check($sformatf("vec%0d", v));
            if (k == 0) begin
               req = 4'b0000;
               pulse_width = 8'd9;
               pulse_gap = 8'($urandom_range(1, 200));
            end
         end
         $display("vec %0d req=%b W=%0d G=%0d expected winner=%0d", v, vecs[v].req, vecs[v].w, vecs[v].g, id);
      end

      // Held requests from a fresh reset: five back-to-back grants, period 2.
      rst = 1'b1;
      push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
      tick_check("reset2");
      rst = 1'b0; req = 4'b1111; pulse_width = 8'd1; pulse_gap = 8'd0; enable = 1'b1;
`ifdef SPIKE_ARB_RR_EN
      rr_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
      rr_ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
      for (int k = 0; k < 5; k++) begin
         push_exp(4'b0001 << rr_ids[k], 1'b1, rr_ids[k], 1'b1);
         push_exp(4'b0000, 1'b0, rr_ids[k], 1'b0);
      end
      for (int k = 0; k < 10; k++) tick_check($sformatf("held_req%0d", k / 2));
      req = 4'b0000;
      $display("held-request sequence: 5 grants");

      // Enable dropped during the pulse: pulse+gap finish, no regrant while low.
      req = 4'b0100; pulse_width = 8'd5; pulse_gap = 8'd3; enable = 1'b1;
      push_train(2'd2, 5, 3, 4);
      n = sb_q.size();
      for (int k = 0; k < n; k++) begin
         tick_check("enable_drop");
         if (k == 0) enable = 1'b0;
      end
      enable = 1'b1;
      push_exp(4'b0100, 1'b1, 2'd2, 1'b1);
      tick_check("enable_regrant");
      $display("enable drop: regrant to 2 one cycle after enable");

      // Reset during the 3rd pulse cycle, with all requests held across it.
      req = 4'b1111;
      push_exp(4'b0000, 1'b1, 2'd2, 1'b1);
      push_exp(4'b0000, 1'b1, 2'd2, 1'b1);
      tick_check("pre_reset_pulse");
      tick_check("pre_reset_pulse");
      rst = 1'b1;
      push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
      tick_check("mid_pulse_reset");
      push_exp(4'b0000, 1'b0, 2'd0, 1'b0);
      tick_check("reset_hold_req");
      rst = 1'b0;
      push_train(2'd0, 5, 3, 1);
      n = sb_q.size();
      for (int k = 0; k < n; k++) begin
         tick_check("post_reset_grant");
         if (k == 0) req = 4'b0000;
      end
      $display("mid-pulse reset: next grant to 0");

      // Request from neuron 1 raised and withdrawn while busy: never granted.
      req = 4'b0001; pulse_width = 8'd4; pulse_gap = 8'd0;
      push_train(2'd0, 4, 0, 4);
      n = sb_q.size();
      for (int k = 0; k < n; k++) begin
         tick_check("withdraw");
         if (k == 0) req = 4'b0000;
         if (k == 1) req = 4'b0010;
         if (k == 2) req = 4'b0000;
      end
      $display("withdrawal: no grant to requester 1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
